cmp_sort_ctrl: RTL
==================

Name: cmp_sort_ctrl

Overview:
- Sequential sorting controller built around a single shared 8-bit magnitude comparator (GT/LT/EQ datapath). One compare-and-swap per clock.
- Accepts a burst of up to DEPTH unsigned bytes over a valid/ready stream and bubble-sorts them ascending in a local buffer.
- Streams the sorted burst out over a second valid/ready port.
- Sits between a byte producer and a consumer; it is the only user of the comparator, so no arbitration is needed.

Parameters:
- WIDTH, 8, element width in bits (unsigned compare).
- DEPTH, 8, maximum burst length (2..16).
- CW, 16, width of the comparison counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input element valid.
- in_data  input  WIDTH  input element.
- in_last  input  1  marks the final element of the burst.
- in_ready  output  1  controller accepts input (LOAD state only).
- out_valid  output  1  sorted element valid.
- out_data  output  WIDTH  sorted element, ascending order.
- out_last  output  1  marks the final sorted element.
- out_ready  input  1  consumer accepts output.
- busy  output  1  high in SORT or DRAIN.
- done  output  1  one-cycle pulse after the last output handshake.
- cmp_count  output  CW  comparisons used for the last burst; holds until the next SORT starts.

Behaviour:
- Reset (async, rst_n=0), all outputs low/zero: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, cmp_count=0.
  - The state machine enters LOAD. Buffer contents are don't-care; the element count is 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- States: LOAD -> SORT -> DRAIN -> LOAD.
- LOAD:
  - in_ready=1.
  - Handshake is in_valid&in_ready: write buf[cnt]=in_data, then cnt++.
  - Exit to SORT on a handshake with in_last=1, or when the handshake fills the buffer (cnt reaches DEPTH). in_last is ignored on a DEPTH-filling beat.
  - in_ready drops in the cycle after the final handshake.
- SORT:
  - Registers: index i and swapped flag. Each cycle compares buf[i] against buf[i+1] through the comparator.
  - If GT=1, swap in the same cycle. cmp_count increments each cycle.
  - When i == cnt-2, the pass ends. If no swap occurred this pass, or cnt-1 passes are complete, go to DRAIN. Otherwise set i=0, clear swapped and start the next pass.
  - Equal elements are never swapped (EQ/LT leave the order unchanged).
  - cnt==1: SORT lasts exactly 1 cycle with no compare; cmp_count=0.
- Sort latency, from the cycle after the last input handshake:
  - Already-sorted burst: cnt-1 cycles.
  - Worst case (reverse-sorted): (cnt-1)^2 cycles.
- DRAIN:
  - out_valid=1; out_data=buf[rd]; out_last=(rd==cnt-1).
  - On out_valid&out_ready, rd++.
  - While out_ready=0, hold out_data stable and keep out_valid high (no drop).
  - After the handshake on the last element: done=1 for one cycle, return to LOAD, cnt=0, rd=0.
  - in_ready reasserts in that same done cycle.
- busy = (state != LOAD).
- Inputs are not accepted during SORT or DRAIN (in_ready=0). in_valid held high is accepted later.
- Reset mid-SORT or mid-DRAIN aborts the burst immediately. Outputs return to reset values and no done pulse is produced.

Test Plan:
- Reverse burst {8,7,6,5,4,3,2,1}, in_last on the 8th element, out_ready=1 -> output 1..8 with out_last on 8; cmp_count=49; done pulses once; 49 SORT cycles.
- Sorted burst {0x01,0x10,0x20,0xFF}, in_last on the 4th -> output unchanged; cmp_count=3; SORT lasts 3 cycles.
- Duplicates and extremes {0xFF,0x00,0x80,0x00,0xFF}, last on the 5th -> output 00,00,80,FF,FF; out_last on the 5th.
- Single element {0x5A} with in_last -> SORT lasts 1 cycle; out 0x5A with out_last=1; cmp_count=0.
- Overfill: 10 elements with no in_last -> first 8 accepted and sorted; in_ready=0 from the cycle after the 8th beat; elements 9-10 are accepted in the next LOAD.
- Backpressure and reset: toggle out_ready 1,0,0,1 during DRAIN -> out_data stable while stalled, no element lost or duplicated. Then assert rst_n=0 mid-SORT -> all outputs 0 immediately, in_ready=1 one cycle after release, no done pulse.

Source files
------------

// File: rtl/cmp_sort_ctrl_if.sv
// Byte stream in / sorted byte stream out, valid/ready on both sides.
interface cmp_sort_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// Burst bubble-sort controller: load up to DEPTH bytes, sort ascending with one
// shared compare-and-swap per clock, then stream the sorted burst out.
module cmp_sort_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    cmp_sort_ctrl_if.slave      s,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       cmp_count
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t             state_q, state_n;
    logic [CNTW-1:0]    cnt_q, cnt_n;
    logic [CNTW-1:0]    pass_q, pass_n;
    logic [IW-1:0]      i_q, i_n;
    logic [IW-1:0]      rd_q, rd_n;
    logic               swapped_q, swapped_n;
    logic [CW-1:0]      cmp_count_q, cmp_count_n;
    logic               in_ready_q, in_ready_n;
    logic               out_valid_q, out_valid_n;
    logic [WIDTH-1:0]   out_data_q, out_data_n;
    logic               out_last_q, out_last_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [WIDTH-1:0]   buf_q [DEPTH];
    logic [WIDTH-1:0]   buf_n [DEPTH];

    logic [WIDTH-1:0]   cmp_a, cmp_b;
    logic               cmp_gt;
    logic               pass_end;
    logic               swap_seen;

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmp_count   = cmp_count_q;

    // Shared magnitude comparator on the adjacent pair under the sort index.
    assign cmp_a    = buf_q[i_q];
    assign cmp_b    = buf_q[i_q + IW'(1)];
    assign cmp_gt   = cmp_a > cmp_b;
    assign pass_end = (CNTW'(i_q) == cnt_q - CNTW'(2));

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        pass_n      = pass_q;
        i_n         = i_q;
        rd_n        = rd_q;
        swapped_n   = swapped_q;
        cmp_count_n = cmp_count_q;
        out_data_n  = out_data_q;
        out_last_n  = out_last_q;
        done_n      = 1'b0;
        buf_n       = buf_q;
        swap_seen   = swapped_q | cmp_gt;

        case (state_q)
            LOAD: begin
                if (s.in_valid && in_ready_q) begin
                    buf_n[IW'(cnt_q)] = s.in_data;
                    cnt_n             = cnt_q + CNTW'(1);
                    if (s.in_last || cnt_n == CNTW'(DEPTH)) begin
                        state_n     = SORT;
                        i_n         = '0;
                        pass_n      = '0;
                        swapped_n   = 1'b0;
                        cmp_count_n = '0;
                    end
                end
            end
            SORT: begin
                if (cnt_q < CNTW'(2)) begin
                    state_n = DRAIN;
                end else begin
                    cmp_count_n = cmp_count_q + CW'(1);
                    if (cmp_gt) begin
                        buf_n[i_q]          = cmp_b;
                        buf_n[i_q + IW'(1)] = cmp_a;
                    end
                    if (pass_end) begin
                        if (!swap_seen || (pass_q + CNTW'(1) == cnt_q - CNTW'(1))) begin
                            state_n = DRAIN;
                        end else begin
                            i_n       = '0;
                            swapped_n = 1'b0;
                            pass_n    = pass_q + CNTW'(1);
                        end
                    end else begin
                        i_n       = i_q + IW'(1);
                        swapped_n = swap_seen;
                    end
                end
                // Present the first sorted element in the first DRAIN cycle.
                if (state_n == DRAIN) begin
                    rd_n       = '0;
                    out_data_n = buf_n[0];
                    out_last_n = (cnt_q == CNTW'(1));
                end
            end
            DRAIN: begin
                if (out_valid_q && s.out_ready) begin
                    if (out_last_q) begin
                        state_n    = LOAD;
                        done_n     = 1'b1;
                        cnt_n      = '0;
                        rd_n       = '0;
                        out_data_n = '0;
                        out_last_n = 1'b0;
                    end else begin
                        rd_n       = rd_q + IW'(1);
                        out_data_n = buf_q[rd_n];
                        out_last_n = (CNTW'(rd_n) == cnt_q - CNTW'(1));
                    end
                end
            end
            default: state_n = LOAD;
        endcase

        in_ready_n  = (state_n == LOAD);
        out_valid_n = (state_n == DRAIN);
        busy_n      = (state_n != LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            pass_q      <= '0;
            i_q         <= '0;
            rd_q        <= '0;
            swapped_q   <= 1'b0;
            cmp_count_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            pass_q      <= pass_n;
            i_q         <= i_n;
            rd_q        <= rd_n;
            swapped_q   <= swapped_n;
            cmp_count_q <= cmp_count_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            out_data_q  <= out_data_n;
            out_last_q  <= out_last_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        buf_q <= buf_n;
    end
endmodule
